pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 imem_ready  input  1  instruction memory returns the instruction for the presented pc this cycle.
REQ-005 advance  input  1  core has completed the current instruction; consume redirect inputs.
REQ-006 branch_taken  input  1  conditional branch resolved taken (branch & condition).
REQ-007 sign_imm  input  32  sign-extended branch immediate, word offset.
REQ-008 jump  input  1  J/JAL redirect request.
REQ-009 jump_index  input  26  instruction index field.
REQ-010 jr  input  1  register-indirect jump request.
REQ-011 jr_target  input  32  register-indirect target address.
REQ-012 fetch_valid  output  1  pc is a valid fetch request.
REQ-013 instr_valid  output  1  fetched instruction is held and executing.
REQ-014 pc  output  32  current instruction address.
REQ-015 pc_plus4  output  32  pc + 4, modulo 2^32.
REQ-016 misalign_err  output  1  sticky fault flag.

Function
REQ-017 FSM states SHALL be BOOT, FETCH, EXEC, FAULT.
REQ-018 BOOT: all outputs deasserted; next state FETCH unconditionally (one cycle).
REQ-019 FETCH: fetch_valid=1; on imem_ready go EXEC, else stay; pc stable while waiting.
REQ-020 EXEC: instr_valid=1, fetch_valid=0; redirect inputs ignored unless advance=1.
REQ-021 On EXEC & advance, next PC SHALL be selected by priority jr > jump > branch_taken > pc_plus4, then state FETCH.
REQ-022 Branch target SHALL be pc_plus4 + {sign_imm[29:0],2'b00}, 32-bit wrap, carry discarded.
REQ-023 Jump target SHALL be {pc_plus4[31:28], jump_index, 2'b00}.
REQ-024 jr selected with jr_target[1:0] != 0: pc unchanged, misalign_err=1, state FAULT.
REQ-025 FAULT: fetch_valid=0, instr_valid=0, misalign_err held 1; exit only via reset.
REQ-026 pc_plus4 SHALL be combinational from pc in every state; 32'hFFFF_FFFC wraps to 0.
REQ-027 Redirect inputs asserted in any state other than EXEC, or without advance, SHALL have no effect.

Reset
REQ-028 reset asserted SHALL immediately force state BOOT, pc=RESET_PC, misalign_err=0, pending redirect cleared, fetch_valid=0, instr_valid=0.
REQ-029 Reset mid-wait (FETCH without imem_ready) or mid-delay-slot SHALL discard all in-flight state.

Configuration
REQ-030 Macro BRANCH_DELAY_SLOT_EN defined: selected redirect target SHALL be stored in a pending register, next pc = pc_plus4 (delay slot), and on that slot's advance pc = pending target; redirect requests during the delay slot are ignored.
REQ-031 Macro undefined: redirect takes effect on the advance edge itself; no pending register exists.
REQ-032 jr misalignment SHALL be detected at selection time in both configurations.

Verification
REQ-033 Reset release, RESET_PC=0, imem_ready=1, advance each EXEC -> pc sequence 0,4,8,C; BOOT lasts one cycle.
REQ-034 pc=0x100, branch_taken=1, sign_imm=32'hFFFF_FFFF, advance -> next pc 0x100 (no delay slot) / 0x104 then 0x100 (BRANCH_DELAY_SLOT_EN).
REQ-035 jr=1, jump=1, branch_taken=1 together, jr_target=0x2000 -> next pc 0x2000.
REQ-036 pc=0x3000_0010, jump_index=26'h000_0040 -> next pc 0x3000_0100.
REQ-037 jr_target=0x2002 -> misalign_err=1, FAULT, fetch_valid=0 until reset; reset clears flag and pc=RESET_PC.
REQ-038 imem_ready held 0 for 5 cycles in FETCH, reset asserted mid-wait -> pc stable throughout, then RESET_PC immediately on reset.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - fetch/redirect bundle between the PC sequencer and its core/memory
interface pc_sequencer_if;
    logic        imem_ready;
    logic        advance;
    logic        branch_taken;
    logic [31:0] sign_imm;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic        fetch_valid;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign_err;

    // sequencer side
    modport master (
        input  imem_ready, advance, branch_taken, sign_imm, jump, jump_index, jr, jr_target,
        output fetch_valid, instr_valid, pc, pc_plus4, misalign_err
    );

    // core / memory side
    modport slave (
        output imem_ready, advance, branch_taken, sign_imm, jump, jump_index, jr, jr_target,
        input  fetch_valid, instr_valid, pc, pc_plus4, misalign_err
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer (BOOT/FETCH/EXEC/FAULT), optional BRANCH_DELAY_SLOT_EN
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.master bus
);
    typedef enum logic [1:0] {BOOT, FETCH, EXEC, FAULT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        misalign_q, misalign_d;
    logic        fetch_valid_c, instr_valid_c;

    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] redirect_target;
    logic        redirect_sel;
    logic        jr_misaligned;
    logic        unused_sign_imm_hi;

`ifdef BRANCH_DELAY_SLOT_EN
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_pc_q, pend_pc_d;
`endif

    assign pc_plus4           = pc_q + 32'd4;
    assign branch_target      = pc_plus4 + {bus.sign_imm[29:0], 2'b00};
    assign jump_target        = {pc_plus4[31:28], bus.jump_index, 2'b00};
    assign jr_misaligned      = bus.jr && (bus.jr_target[1:0] != 2'b00);
    assign redirect_sel       = bus.jr || bus.jump || bus.branch_taken;
    // the top immediate bits fall off the word shift
    assign unused_sign_imm_hi = &{1'b0, bus.sign_imm[31:30]};

    // redirect priority: jr over jump over branch over sequential
    always_comb begin
        redirect_target = pc_plus4;
        if (bus.jr) begin
            redirect_target = bus.jr_target;
        end else if (bus.jump) begin
            redirect_target = jump_target;
        end else if (bus.branch_taken) begin
            redirect_target = branch_target;
        end
    end

    // next-state, next-pc and fetch/execute strobes
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        misalign_d    = misalign_q;
        fetch_valid_c = 1'b0;
        instr_valid_c = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
        pend_valid_d  = pend_valid_q;
        pend_pc_d     = pend_pc_q;
`endif
        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                fetch_valid_c = 1'b1;
                if (bus.imem_ready) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                instr_valid_c = 1'b1;
                if (bus.advance) begin
`ifdef BRANCH_DELAY_SLOT_EN
                    if (pend_valid_q) begin
                        // delay slot retires: jump to the held target, ignore new redirects
                        pc_d         = pend_pc_q;
                        pend_valid_d = 1'b0;
                        state_d      = FETCH;
                    end else if (jr_misaligned) begin
                        misalign_d = 1'b1;
                        state_d    = FAULT;
                    end else begin
                        pc_d    = pc_plus4;
                        state_d = FETCH;
                        if (redirect_sel) begin
                            pend_valid_d = 1'b1;
                            pend_pc_d    = redirect_target;
                        end
                    end
`else
                    if (jr_misaligned) begin
                        misalign_d = 1'b1;
                        state_d    = FAULT;
                    end else begin
                        pc_d    = redirect_target;
                        state_d = FETCH;
                    end
`endif
                end
            end
            FAULT: begin
                misalign_d = 1'b1;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // state registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            misalign_q   <= 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
            pend_valid_q <= 1'b0;
            pend_pc_q    <= 32'h0000_0000;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            misalign_q   <= misalign_d;
`ifdef BRANCH_DELAY_SLOT_EN
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
`endif
        end
    end

    assign bus.fetch_valid  = fetch_valid_c;
    assign bus.instr_valid  = instr_valid_c;
    assign bus.pc           = pc_q;
    assign bus.pc_plus4     = pc_plus4;
    assign bus.misalign_err = misalign_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer with an instruction-level reference model
module tb_pc_sequencer;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int P_BOOT = 0, P_FETCH = 1, P_EXEC = 2, P_FAULT = 3;

    typedef struct {
        bit          is_fault;
        logic [31:0] pc;
    } exp_t;

    logic clk;
    logic reset;
    pc_sequencer_if bus();

    pc_sequencer #(.RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_fetch = 0;
    exp_t        exp_q[$];
    logic [31:0] pend_q[$];
    int          m_phase = P_BOOT;
    logic [31:0] m_pc = RESET_PC;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: pops one expectation per fetch handshake or fault entry
    initial begin
        exp_t e;
        bit   prev_err;
        prev_err = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_err = 1'b0;
            end else begin
                if (bus.fetch_valid && bus.imem_ready) begin
                    n_fetch++;
                    if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL fetch_unexpected: got pc %h expected no fetch", bus.pc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("fetch_kind", {31'd0, 1'b0}, {31'd0, e.is_fault});
                        chk("fetch_pc", bus.pc, e.pc);
                        chk("fetch_pc_plus4", bus.pc_plus4, e.pc + 32'd4);
                    end
                end
                if (bus.misalign_err && !prev_err) begin
                    if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL fault_unexpected: got misalign_err at pc %h expected none", bus.pc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("fault_kind", {31'd0, 1'b1}, {31'd0, e.is_fault});
                        chk("fault_pc", bus.pc, e.pc);
                    end
                end
                if (bus.misalign_err) begin
                    chk("fault_fetch_valid", {31'd0, bus.fetch_valid}, 32'd0);
                    chk("fault_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
                end
                prev_err = bus.misalign_err;
            end
        end
    end

    task automatic set_idle();
        bus.imem_ready = 1'b0; bus.advance = 1'b0; bus.branch_taken = 1'b0;
        bus.sign_imm = 32'd0; bus.jump = 1'b0; bus.jump_index = 26'd0;
        bus.jr = 1'b0; bus.jr_target = 32'd0;
    endtask

    // drive one cycle of inputs, advance the model across the coming edge, then check phase strobes
    task automatic step(input bit ir, input bit adv, input bit br, input logic [31:0] simm,
                        input bit jmp, input logic [25:0] jidx, input bit jrr, input logic [31:0] jtgt);
        logic [31:0] p4;
        logic [31:0] tgt;
        exp_t        e;
        bus.imem_ready = ir; bus.advance = adv; bus.branch_taken = br; bus.sign_imm = simm;
        bus.jump = jmp; bus.jump_index = jidx; bus.jr = jrr; bus.jr_target = jtgt;
        case (m_phase)
            P_BOOT: m_phase = P_FETCH;
            P_FETCH: if (ir) begin
                e.is_fault = 1'b0; e.pc = m_pc;
                exp_q.push_back(e);
                m_phase = P_EXEC;
            end
            P_EXEC: if (adv) begin
                p4 = m_pc + 32'd4;
                if (pend_q.size() != 0) begin
                    m_pc = pend_q.pop_front();
                    m_phase = P_FETCH;
                end else if (jrr && (jtgt % 4) != 0) begin
                    e.is_fault = 1'b1; e.pc = m_pc;
                    exp_q.push_back(e);
                    m_phase = P_FAULT;
                end else begin
                    if (jrr) tgt = jtgt;
                    else if (jmp) tgt = {p4[31:28], jidx, 2'b00};
                    else if (br) tgt = p4 + simm * 4;
                    else tgt = p4;
`ifdef BRANCH_DELAY_SLOT_EN
                    if (jrr || jmp || br) pend_q.push_back(tgt);
                    m_pc = p4;
`else
                    m_pc = tgt;
`endif
                    m_phase = P_FETCH;
                end
            end
            default: ;
        endcase
        @(posedge clk); #1;
        chk("fetch_valid", {31'd0, bus.fetch_valid}, {31'd0, m_phase == P_FETCH});
        chk("instr_valid", {31'd0, bus.instr_valid}, {31'd0, m_phase == P_EXEC});
        chk("misalign_err", {31'd0, bus.misalign_err}, {31'd0, m_phase == P_FAULT});
    endtask

    task automatic retire(input bit br, input logic [31:0] simm, input bit jmp,
                          input logic [25:0] jidx, input bit jrr, input logic [31:0] jtgt);
        int guard;
        guard = 0;
        while (m_phase != P_EXEC && guard < 8) begin
            step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0);
            guard++;
        end
        if (m_phase != P_EXEC) begin
            n_vec++; n_err++;
            $display("FAIL retire_timeout: got no EXEC within %0d cycles expected EXEC", guard);
        end else begin
            step(1'b1, 1'b1, br, simm, jmp, jidx, jrr, jtgt);
        end
    endtask

    task automatic retire_plain();
        retire(1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0);
    endtask

    // land the pc on an aligned address through a register jump
    task automatic goto(input logic [31:0] addr);
        retire(1'b0, 32'd0, 1'b0, 26'd0, 1'b1, addr);
`ifdef BRANCH_DELAY_SLOT_EN
        retire_plain();
`endif
    endtask

    task automatic do_reset();
        set_idle();
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete(); pend_q.delete();
        m_pc = RESET_PC; m_phase = P_BOOT;
        #1;
        chk("rst_pc", bus.pc, RESET_PC);
        chk("rst_fetch_valid", {31'd0, bus.fetch_valid}, 32'd0);
        chk("rst_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_misalign", {31'd0, bus.misalign_err}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("boot_fetch_valid", {31'd0, bus.fetch_valid}, 32'd0);
        chk("boot_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
        @(posedge clk); #1;
        m_phase = P_FETCH;
        @(negedge clk);
        chk("boot_done_fetch_valid", {31'd0, bus.fetch_valid}, 32'd1);
        chk("boot_done_pc", bus.pc, RESET_PC);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] jt;
        reset = 1'b1;
        set_idle();
        @(posedge clk); #1;
        do_reset();

        // straight-line fetch 0,4,8,C
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0);

        // backwards branch of one word from 0x100
        goto(32'h0000_0100);
        retire(1'b1, 32'hFFFF_FFFF, 1'b0, 26'd0, 1'b0, 32'd0);
        retire_plain(); retire_plain();

        // jr wins over jump and branch
        goto(32'h0000_0040);
        retire(1'b1, 32'd7, 1'b1, 26'd5, 1'b1, 32'h0000_2000);
        retire_plain(); retire_plain();

        // jump keeps the upper nibble of pc+4
        goto(32'h3000_0010);
        retire(1'b0, 32'd0, 1'b1, 26'h000_0040, 1'b0, 32'd0);
        retire_plain(); retire_plain();

        // pc+4 wraps at the top of the address space
        goto(32'hFFFF_FFFC);
        retire_plain(); retire_plain();

        // misaligned jr faults and stays faulted
        goto(32'h0000_0080);
        retire(1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'h0000_2002);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, 32'd3, 1'b1, 26'd9, 1'b1, 32'h0000_4000);
        do_reset();

        // fetch stall with pc held, then reset mid-wait
        goto(32'h0000_0500);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b1, 32'd1, 1'b1, 26'd1, 1'b1, 32'h0000_0700);
            chk("stall_pc", bus.pc, m_pc);
        end
        do_reset();

        // randomized traffic, periodically reset
        for (int blk = 0; blk < 20; blk++) begin
            for (int i = 0; i < 60; i++) begin
                jt = $urandom() & 32'hFFFF_FFFC;
                if ($urandom_range(0, 19) == 0) jt = jt | $urandom_range(1, 3);
                step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                     $urandom_range(0, 3) == 0, $urandom() - 32'h8000_0000,
                     $urandom_range(0, 3) == 0, 26'($urandom()),
                     $urandom_range(0, 3) == 0, jt);
            end
            do_reset();
        end

        set_idle();
        @(negedge clk);
        chk("final_queue_drained", exp_q.size(), 32'd0);
        n_vec++;
        if (n_fetch < 100) begin
            n_err++;
            $display("FAIL fetch_progress: got %0d fetches expected at least 100", n_fetch);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
